// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg -- definitions shared by the push-button front end.
//
//   key_fsm_e     : per-key debounce FSM state encoding
//   led_mode_e    : LED mode select encoding driven out on key_input_ctrl.mode
//   NUM_KEYS      : number of push-buttons handled by key_input_ctrl
//   ms_to_cycles  : converts a millisecond window into pll_clk cycles
// ---------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } key_fsm_e;

    typedef enum logic [1:0] {
        MODE_MARQUEE = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_BREATHE = 2'd2
    } led_mode_e;

    localparam int unsigned NUM_KEYS = 4;

    // Cycles in a window of 'ms' milliseconds, computed as clk_freq/1000*ms
    // in 32-bit unsigned arithmetic. Never returns 0 so that "count-1"
    // comparisons downstream stay meaningful for very slow clocks.
    function automatic logic [31:0] ms_to_cycles(input logic [31:0] clk_freq,
                                                 input logic [31:0] ms);
        logic [31:0] cycles;
        cycles = (clk_freq / 32'd1000) * ms;
        if (cycles == 32'd0) begin
            return 32'd1;
        end else begin
            return cycles;
        end
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce -- one push-button: 2-flop synchronizer, polarity
// normalization, debounce FSM and (optionally) long-press detection.
//
// Configuration macro: KEY_LONG_PRESS_EN
//   defined   : a hold counter runs while HELD and key_long pulses once when
//               it reaches LP_CNT-1 (then saturates until the next press).
//   undefined : no hold counter; key_long is tied to 0.
//
// Ports
//   pll_clk     in  clock
//   rst_sync    in  asynchronous active-high reset
//   key_raw     in  raw asynchronous button pin
//   key_state   out debounced level, 1 = held
//   key_press   out one-cycle pulse on confirmed press
//   key_release out one-cycle pulse on confirmed release
//   key_long    out one-cycle pulse on long press
// ---------------------------------------------------------------------------
module key_debounce
    import led_pkg::*;
#(
    parameter logic [31:0] DB_CNT         = 32'd1,
`ifdef KEY_LONG_PRESS_EN
    parameter logic [31:0] LP_CNT         = 32'd1,
`endif
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic pll_clk,
    input  logic rst_sync,
    input  logic key_raw,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    logic        sync1_q;
    logic        sync2_q;
    // Shift register that fills with ones after reset; the FSM ignores the
    // synchronizer until it holds a real sample instead of its reset zero.
    // This keeps a key held through reset from being seen early and gives
    // the same DB_CNT+3 latency from reset release as from a clean edge.
    logic [1:0]  fill_q;
    logic [1:0]  fill_d;
    key_fsm_e    fsm_q;
    key_fsm_e    fsm_d;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        state_q;
    logic        state_d;
    logic        press_q;
    logic        press_d;
    logic        release_q;
    logic        release_d;
    logic        key_norm_s;
    logic        key_act_s;

    // Debounce FSM next-state, counter and pulse generation.
    always_comb begin
        fill_d     = {fill_q[0], 1'b1};
        key_norm_s = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;
        key_act_s  = fill_q[1] & key_norm_s;
        fsm_d      = fsm_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                cnt_d = 32'd0;
                if (key_act_s) begin
                    fsm_d = PRESS_DB;
                end else begin
                    fsm_d = IDLE;
                end
            end
            PRESS_DB: begin
                if (!key_act_s) begin
                    fsm_d = IDLE;
                    cnt_d = 32'd0;
                end else if (cnt_q == DB_CNT - 32'd1) begin
                    fsm_d   = HELD;
                    cnt_d   = 32'd0;
                    state_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            HELD: begin
                cnt_d = 32'd0;
                if (!key_act_s) begin
                    fsm_d = REL_DB;
                end else begin
                    fsm_d = HELD;
                end
            end
            REL_DB: begin
                if (key_act_s) begin
                    fsm_d = HELD;
                    cnt_d = 32'd0;
                end else if (cnt_q == DB_CNT - 32'd1) begin
                    fsm_d     = IDLE;
                    cnt_d     = 32'd0;
                    state_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                fsm_d   = IDLE;
                cnt_d   = 32'd0;
                state_d = 1'b0;
            end
        endcase
    end

`ifdef KEY_LONG_PRESS_EN
    logic [31:0] hold_q;
    logic [31:0] hold_d;
    logic        long_q;
    logic        long_d;

    // Hold counter: cleared on entry to HELD, counts while the key stays
    // held and saturates at LP_CNT-1 so the long pulse fires only once.
    // Release-debounce bounces back to HELD keep the count.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if ((fsm_q == PRESS_DB) && (fsm_d == HELD)) begin
            hold_d = 32'd0;
            long_d = (LP_CNT == 32'd1);
        end else if ((fsm_q == HELD) && (fsm_d == HELD)) begin
            if (hold_q != LP_CNT - 32'd1) begin
                hold_d = hold_q + 32'd1;
                long_d = (hold_q + 32'd1 == LP_CNT - 32'd1);
            end else begin
                hold_d = hold_q;
            end
        end else begin
            hold_d = hold_q;
        end
    end

    // Hold counter and long-press pulse registers.
    always_ff @(posedge pll_clk or posedge rst_sync) begin
        if (rst_sync) begin
            hold_q <= 32'd0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign key_long = long_q;
`else
    assign key_long = 1'b0;
`endif

    // Synchronizer, FSM state, debounce counter and registered outputs.
    always_ff @(posedge pll_clk or posedge rst_sync) begin
        if (rst_sync) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            fill_q    <= 2'b00;
            fsm_q     <= IDLE;
            cnt_q     <= 32'd0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= key_raw;
            sync2_q   <= sync1_q;
            fill_q    <= fill_d;
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_state   = state_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_input_ctrl.sv
// ---------------------------------------------------------------------------
// key_input_ctrl -- four debounced push-buttons plus LED mode selection.
// Key 0 steps the mode marquee -> blink -> breathe -> marquee; key 1 forces
// marquee and wins if both press pulses coincide.
//
// Configuration macro: KEY_LONG_PRESS_EN (enables key_long, see key_debounce)
//
// Parameters
//   CLK_FREQ       pll_clk frequency in Hz
//   DEBOUNCE_MS    debounce window in ms
//   LONG_PRESS_MS  long-press threshold in ms
//   KEY_ACTIVE_LOW 1: a pressed key reads 0 on keys_in
//
// Ports
//   pll_clk     in  clock
//   rst_sync    in  asynchronous active-high reset
//   keys_in     in  [3:0] raw asynchronous button pins
//   key_state   out [3:0] debounced level, 1 = held
//   key_press   out [3:0] one-cycle pulse per confirmed press
//   key_release out [3:0] one-cycle pulse per confirmed release
//   key_long    out [3:0] one-cycle pulse per long press
//   mode        out [1:0] 0 = marquee, 1 = blink, 2 = breathe
// ---------------------------------------------------------------------------
module key_input_ctrl
    import led_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 200_000_000,
    parameter int unsigned DEBOUNCE_MS    = 20,
    parameter int unsigned LONG_PRESS_MS  = 1000,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic       pll_clk,
    input  logic       rst_sync,
    input  logic [3:0] keys_in,
    output logic [3:0] key_state,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long,
    output logic [1:0] mode
);

    localparam logic [31:0] DB_CNT = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
`ifdef KEY_LONG_PRESS_EN
    localparam logic [31:0] LP_CNT = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
`endif

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DB_CNT         (DB_CNT),
`ifdef KEY_LONG_PRESS_EN
            .LP_CNT         (LP_CNT),
`endif
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_key_debounce (
            .pll_clk     (pll_clk),
            .rst_sync    (rst_sync),
            .key_raw     (keys_in[i]),
            .key_state   (key_state[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

    led_mode_e mode_q;
    led_mode_e mode_d;

    // Mode sequencing; key 1 has priority over key 0.
    always_comb begin
        mode_d = mode_q;
        if (key_press[1]) begin
            mode_d = MODE_MARQUEE;
        end else if (key_press[0]) begin
            case (mode_q)
                MODE_MARQUEE: mode_d = MODE_BLINK;
                MODE_BLINK:   mode_d = MODE_BREATHE;
                MODE_BREATHE: mode_d = MODE_MARQUEE;
                default:      mode_d = MODE_MARQUEE;
            endcase
        end else begin
            mode_d = mode_q;
        end
    end

    // Mode register.
    always_ff @(posedge pll_clk or posedge rst_sync) begin
        if (rst_sync) begin
            mode_q <= MODE_MARQUEE;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_key_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_input_ctrl -- table-driven bench for key_input_ctrl with
// CLK_FREQ=1000, DEBOUNCE_MS=4, LONG_PRESS_MS=10 (DB_CNT=4, LP_CNT=10),
// active-low keys. Each record holds inputs for 'cyc' cycles; on every
// cycle but the last all pulse outputs must be 0, on the last cycle all
// outputs must match the record.
// ---------------------------------------------------------------------------
module tb_key_input_ctrl;

    logic       pll_clk  = 1'b0;
    logic       rst_sync = 1'b0;
    logic [3:0] keys_in  = 4'hF;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;
    logic [1:0] mode;

    always #5 pll_clk = ~pll_clk;

    key_input_ctrl #(
        .CLK_FREQ       (1000),
        .DEBOUNCE_MS    (4),
        .LONG_PRESS_MS  (10),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .pll_clk     (pll_clk),
        .rst_sync    (rst_sync),
        .keys_in     (keys_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .mode        (mode)
    );

`ifdef KEY_LONG_PRESS_EN
    localparam logic [3:0] LG0 = 4'b0001;
    localparam logic [3:0] LG3 = 4'b1000;
`else
    localparam logic [3:0] LG0 = 4'b0000;
    localparam logic [3:0] LG3 = 4'b0000;
`endif

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] keys;
        int         cyc;
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lg;
        logic [1:0] md;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input string name, input logic rst, input logic [3:0] keys,
                       input int cyc, input logic [3:0] st, input logic [3:0] pr,
                       input logic [3:0] rl, input logic [3:0] lg, input logic [1:0] md);
        vec_t v;
        v.name = name; v.rst = rst; v.keys = keys; v.cyc = cyc;
        v.st = st; v.pr = pr; v.rl = rl; v.lg = lg; v.md = md;
        tbl.push_back(v);
    endtask

    // Clean press held 8 cycles then released: press pulse on cycle 7,
    // mode update one cycle later, release pulse 7 cycles after release.
    task automatic press_seq(input string name, input logic [3:0] keys, input logic [3:0] m,
                             input logic [1:0] md0, input logic [1:0] md1);
        add({name, "_wait"},  1'b0, keys,  6, 4'h0, 4'h0, 4'h0, 4'h0, md0);
        add({name, "_press"}, 1'b0, keys,  1, m,    m,    4'h0, 4'h0, md0);
        add({name, "_mode"},  1'b0, keys,  1, m,    4'h0, 4'h0, 4'h0, md1);
        add({name, "_rwait"}, 1'b0, 4'hF,  6, m,    4'h0, 4'h0, 4'h0, md1);
        add({name, "_rel"},   1'b0, 4'hF,  1, 4'h0, 4'h0, m,    4'h0, md1);
        add({name, "_after"}, 1'b0, 4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0, md1);
    endtask

    initial begin
        //  name          rst   keys  cyc  state press rel  long  mode
        add("reset",      1'b1, 4'hF, 2,   4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        add("idle",       1'b0, 4'hF, 4,   4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        // key0 clean press held 20 cycles
        add("k0_wait",    1'b0, 4'hE, 6,   4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        add("k0_press",   1'b0, 4'hE, 1,   4'h1, 4'h1, 4'h0, 4'h0, 2'd0);
        add("k0_mode",    1'b0, 4'hE, 1,   4'h1, 4'h0, 4'h0, 4'h0, 2'd1);
        add("k0_hold",    1'b0, 4'hE, 7,   4'h1, 4'h0, 4'h0, 4'h0, 2'd1);
        add("k0_hold16",  1'b0, 4'hE, 1,   4'h1, 4'h0, 4'h0, LG0,  2'd1);
        add("k0_hold20",  1'b0, 4'hE, 4,   4'h1, 4'h0, 4'h0, 4'h0, 2'd1);
        add("k0_rwait",   1'b0, 4'hF, 6,   4'h1, 4'h0, 4'h0, 4'h0, 2'd1);
        add("k0_rel",     1'b0, 4'hF, 1,   4'h0, 4'h0, 4'h1, 4'h0, 2'd1);
        add("k0_after",   1'b0, 4'hF, 1,   4'h0, 4'h0, 4'h0, 4'h0, 2'd1);
        // key2 bounce: low 3, high 2, low 3, then high
        add("k2_b1",      1'b0, 4'hB, 3,   4'h0, 4'h0, 4'h0, 4'h0, 2'd1);
        add("k2_b2",      1'b0, 4'hF, 2,   4'h0, 4'h0, 4'h0, 4'h0, 2'd1);
        add("k2_b3",      1'b0, 4'hB, 3,   4'h0, 4'h0, 4'h0, 4'h0, 2'd1);
        add("k2_b4",      1'b0, 4'hF, 8,   4'h0, 4'h0, 4'h0, 4'h0, 2'd1);
        // mode wrap and key1 priority
        press_seq("k0_b",    4'hE, 4'h1, 2'd1, 2'd2);
        press_seq("k0_c",    4'hE, 4'h1, 2'd2, 2'd0);
        press_seq("k0_d",    4'hE, 4'h1, 2'd0, 2'd1);
        press_seq("k01_sim", 4'hC, 4'h3, 2'd1, 2'd0);
        // key3 long press held 30 cycles
        add("k3_wait",    1'b0, 4'h7, 6,   4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        add("k3_press",   1'b0, 4'h7, 1,   4'h8, 4'h8, 4'h0, 4'h0, 2'd0);
        add("k3_hold",    1'b0, 4'h7, 8,   4'h8, 4'h0, 4'h0, 4'h0, 2'd0);
        add("k3_long",    1'b0, 4'h7, 1,   4'h8, 4'h0, 4'h0, LG3,  2'd0);
        add("k3_sat",     1'b0, 4'h7, 14,  4'h8, 4'h0, 4'h0, 4'h0, 2'd0);
        add("k3_rwait",   1'b0, 4'hF, 6,   4'h8, 4'h0, 4'h0, 4'h0, 2'd0);
        add("k3_rel",     1'b0, 4'hF, 1,   4'h0, 4'h0, 4'h8, 4'h0, 2'd0);
        add("k3_after",   1'b0, 4'hF, 1,   4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        // reset while key1 (and key0) held, mode at blink
        add("k1_wait",    1'b0, 4'hD, 6,   4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        add("k1_press",   1'b0, 4'hD, 1,   4'h2, 4'h2, 4'h0, 4'h0, 2'd0);
        add("k10_wait",   1'b0, 4'hC, 6,   4'h2, 4'h0, 4'h0, 4'h0, 2'd0);
        add("k10_press",  1'b0, 4'hC, 1,   4'h3, 4'h1, 4'h0, 4'h0, 2'd0);
        add("k10_mode",   1'b0, 4'hC, 1,   4'h3, 4'h0, 4'h0, 4'h0, 2'd1);
        add("mid_reset",  1'b1, 4'hC, 1,   4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        add("rd_wait",    1'b0, 4'hC, 6,   4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        add("rd_press",   1'b0, 4'hC, 1,   4'h3, 4'h3, 4'h0, 4'h0, 2'd0);
        add("rd_mode",    1'b0, 4'hC, 1,   4'h3, 4'h0, 4'h0, 4'h0, 2'd0);
        add("rd_rwait",   1'b0, 4'hF, 6,   4'h3, 4'h0, 4'h0, 4'h0, 2'd0);
        add("rd_rel",     1'b0, 4'hF, 1,   4'h0, 4'h0, 4'h3, 4'h0, 2'd0);
        add("rd_after",   1'b0, 4'hF, 1,   4'h0, 4'h0, 4'h0, 4'h0, 2'd0);

        #1 rst_sync = 1'b1;
        @(negedge pll_clk);
        foreach (tbl[i]) begin
            rst_sync = tbl[i].rst;
            keys_in  = tbl[i].keys;
            for (int c = 1; c <= tbl[i].cyc; c++) begin
                @(posedge pll_clk);
                @(negedge pll_clk);
                n_vec++;
                if (c < tbl[i].cyc) begin
                    if ({key_press, key_release, key_long} !== 12'h000) begin
                        n_bad++;
                        $display("FAIL %s_quiet cyc %0d: got press=%b release=%b long=%b, want all 0000",
                                 tbl[i].name, c, key_press, key_release, key_long);
                    end
                end else begin
                    if (key_state !== tbl[i].st || key_press !== tbl[i].pr ||
                        key_release !== tbl[i].rl || key_long !== tbl[i].lg ||
                        mode !== tbl[i].md) begin
                        n_bad++;
                        $display("FAIL %s: got state=%b press=%b release=%b long=%b mode=%0d, want state=%b press=%b release=%b long=%b mode=%0d",
                                 tbl[i].name, key_state, key_press, key_release, key_long, mode,
                                 tbl[i].st, tbl[i].pr, tbl[i].rl, tbl[i].lg, tbl[i].md);
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/key_input_ctrl.md
KEY_INPUT_CTRL -- requirements
Module: key_input_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 200_000_000, clock frequency in Hz.
REQ-002 The block SHALL have parameter DEBOUNCE_MS, default 20, debounce window in ms.
REQ-003 The block SHALL have parameter LONG_PRESS_MS, default 1000, long-press threshold in ms.
REQ-004 The block SHALL have parameter KEY_ACTIVE_LOW, default 1; 1 means a pressed key reads 0.
REQ-005 The block SHALL have port pll_clk, input, 1 bit, the clock.
REQ-006 The block SHALL have port rst_sync, input, 1 bit, reset (asynchronous, active-high).
REQ-007 The block SHALL have port keys_in, input, 4 bits, raw asynchronous push-button pins.
REQ-008 The block SHALL have port key_state, output, 4 bits, debounced level (1 = held).
REQ-009 The block SHALL have port key_press, output, 4 bits, one-cycle pulse per confirmed press.
REQ-010 The block SHALL have port key_release, output, 4 bits, one-cycle pulse per confirmed release.
REQ-011 The block SHALL have port key_long, output, 4 bits, one-cycle pulse on long-press (see REQ-026).
REQ-012 The block SHALL have port mode, output, 2 bits, LED mode select: 0 = marquee, 1 = blink, 2 = breathe.

Function
REQ-013 Each keys_in bit SHALL pass through a 2-flop synchronizer, then be polarity-normalized per KEY_ACTIVE_LOW, before any other logic uses it.
REQ-014 DB_CNT SHALL equal CLK_FREQ/1000*DEBOUNCE_MS. LP_CNT SHALL equal CLK_FREQ/1000*LONG_PRESS_MS. Both use 32-bit unsigned arithmetic. Both SHALL be at least 1.
REQ-015 Each key SHALL run an independent FSM with states IDLE, PRESS_DB, HELD and REL_DB, plus its own 32-bit counter.
REQ-016 IDLE: if the normalized input is active, the FSM SHALL go to PRESS_DB with counter = 0.
REQ-017 PRESS_DB: if the input is inactive, the FSM SHALL return to IDLE with counter = 0. If counter == DB_CNT-1 and the input is active, the FSM SHALL go to HELD. Otherwise counter SHALL increment.
REQ-018 On entry to HELD, key_press[i] SHALL be 1 for exactly one cycle and key_state[i] SHALL become 1.
REQ-019 HELD/REL_DB SHALL mirror REQ-016/017 with the input sense inverted. Completing the release debounce SHALL go to IDLE, pulse key_release[i] for one cycle and clear key_state[i].
REQ-020 A bounce shorter than DB_CNT cycles SHALL produce no pulse and no key_state change.
REQ-021 Latency SHALL be exactly DB_CNT+3 pll_clk cycles from a clean raw edge to the key_press/key_release pulse.
REQ-022 mode SHALL advance 0->1->2->0 on key_press[0]. It SHALL go to 0 on key_press[1]. If both pulse in the same cycle, key_press[1] SHALL win.
REQ-023 All outputs SHALL be registered; no combinational path from keys_in to any output.

Reset
REQ-024 While rst_sync = 1: all FSMs SHALL be IDLE, and counters, synchronizers, key_state, key_press, key_release, key_long and mode SHALL be 0.
REQ-025 Reset mid-debounce or mid-hold SHALL emit no pulse. A key still held after reset release SHALL be re-debounced from IDLE.

Configuration
REQ-026 With KEY_LONG_PRESS_EN defined, each key SHALL have a hold counter in HELD. key_long[i] SHALL pulse once when the hold counter reaches LP_CNT-1. The counter SHALL then saturate, giving no repeat until the key is released and pressed again.
REQ-027 With KEY_LONG_PRESS_EN undefined, key_long SHALL be tied to 0 and no hold counter SHALL exist.

Structure
REQ-028 The FSM state encoding (IDLE, PRESS_DB, HELD, REL_DB), the mode encodings (MODE_MARQUEE = 0, MODE_BLINK = 1, MODE_BREATHE = 2) and the ms-to-cycles constant function SHALL live in shared package led_pkg.
REQ-029 Per-key synchronizer, FSM and counters SHALL be sub-module key_debounce, instantiated 4 times. The mode register SHALL stay in key_input_ctrl.

Verification (CLK_FREQ = 1000, DEBOUNCE_MS = 4, LONG_PRESS_MS = 10, so DB_CNT = 4 and LP_CNT = 10; KEY_ACTIVE_LOW = 1)
REQ-030 Clean press: keys_in[0] 1->0 held 20 cycles -> key_press[0] one-cycle pulse exactly 7 cycles after the edge, key_state[0] = 1, mode 0->1.
REQ-031 Bounce: keys_in[2] low 3 cycles, high 2, low 3, then high -> no pulses, key_state[2] stays 0.
REQ-032 Mode wrap: three clean presses of key0 -> mode 1, 2, 0. Simultaneous press of key0 and key1 from mode 1 -> mode 0.
REQ-033 Long press (macro on): hold key3 for 30 cycles -> key_press[3] once, key_long[3] once, key_release[3] once after release. Macro off -> key_long = 0 throughout.
REQ-034 Reset mid-hold: key1 in HELD, pulse rst_sync 1 cycle with key still held -> all outputs 0, key_state[1] returns to 1 DB_CNT+3 cycles after reset release, key_press[1] pulses once.
